// File: rtl/ws2812_frame_scheduler.sv
// Frame-rate scheduler for a shared WS2812 chain: paced ticks, round-robin source pick,
// shadow-latched frame and a driver update/busy handshake guarded by a busy watchdog.
module ws2812_frame_scheduler #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned PIXELS       = 256,
  parameter int unsigned FRAME_PERIOD = 400000,
  parameter int unsigned BUSY_TIMEOUT = 200000,
  localparam int unsigned SrcW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*PIXELS-1:0]   frame_in,
  output logic [NUM_REQ-1:0]          ack,
  input  logic                        drv_busy,
  output logic                        drv_update,
  output logic [PIXELS-1:0]           drv_frame,
  output logic [SrcW-1:0]             active_src,
  output logic [15:0]                 frame_count,
  output logic                        overrun,
  output logic                        timeout_err,
  input  logic                        err_clr
);

  localparam int unsigned TickW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int unsigned WdW   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(FRAME_PERIOD - 1);
  localparam logic [WdW-1:0]   WdLast   = WdW'(BUSY_TIMEOUT - 1);
  localparam logic [SrcW-1:0]  SrcLast  = SrcW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    StIdle, StArb, StWaitIdle, StStart, StWaitHi, StWaitLo
  } state_e;

  state_e              state_q, state_d;
  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic                tick_pending_q, tick_pending_d;
  logic [WdW-1:0]      wd_cnt_q, wd_cnt_d;
  logic [SrcW-1:0]     last_grant_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                update_q, overrun_q, timeout_q;
  logic [PIXELS-1:0]   frame_q;
  logic [SrcW-1:0]     src_q;
  logic [15:0]         count_q;

  logic                tick, wd_expire, timeout_set, frame_done, grant_valid, latch;
  logic [SrcW-1:0]     grant_idx;
  logic [PIXELS-1:0]   sel_frame;

  assign tick      = enable && (tick_cnt_q == TickLast);
  assign wd_expire = (wd_cnt_q == WdLast);
  assign latch     = (state_q == StArb) && grant_valid;

  always_comb begin
    tick_cnt_d     = tick_cnt_q + TickW'(1);
    tick_pending_d = tick_pending_q;
    if (!enable) begin
      tick_cnt_d     = '0;
      tick_pending_d = 1'b0;
    end else begin
      if (tick) tick_cnt_d = '0;
      if (state_q == StArb) tick_pending_d = 1'b0;
      // A tick landing in the ARB cycle re-queues rather than being lost.
      if (tick) tick_pending_d = 1'b1;
    end
  end

  // Round-robin: the smallest offset from last_grant+1 is assigned last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      int cand;
      cand = (int'(last_grant_q) + i) % int'(NUM_REQ);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = SrcW'(cand);
      end
    end
  end

  always_comb begin
    sel_frame = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_idx == SrcW'(i)) sel_frame = frame_in[i*PIXELS +: PIXELS];
    end
  end

  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    frame_done  = 1'b0;
    unique case (state_q)
      StIdle:     if (tick_pending_q && enable) state_d = StArb;
      StArb:      state_d = grant_valid ? StWaitIdle : StIdle;
      StWaitIdle: begin
        if (!drv_busy) state_d = StStart;
        else if (wd_expire) timeout_set = 1'b1;
      end
      StStart:    state_d = StWaitHi;
      StWaitHi: begin
        if (drv_busy) state_d = StWaitLo;
        else if (wd_expire) timeout_set = 1'b1;
      end
      StWaitLo: begin
        if (!drv_busy) begin
          state_d    = StIdle;
          frame_done = 1'b1;
        end else if (wd_expire) begin
          timeout_set = 1'b1;
        end
      end
      default:    state_d = StIdle;
    endcase
    if (timeout_set) state_d = StIdle;
  end

  always_comb begin
    wd_cnt_d = wd_cnt_q + WdW'(1);
    if (state_d != state_q || state_q == StIdle || state_q == StArb || state_q == StStart) begin
      wd_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      tick_cnt_q     <= '0;
      tick_pending_q <= 1'b0;
      wd_cnt_q       <= '0;
      last_grant_q   <= SrcLast;
      ack_q          <= '0;
      update_q       <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
      frame_q        <= '0;
      src_q          <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      tick_pending_q <= tick_pending_d;
      wd_cnt_q       <= wd_cnt_d;
      ack_q          <= latch ? (NUM_REQ'(1) << grant_idx) : '0;
      update_q       <= (state_q == StWaitIdle) && !drv_busy;
      overrun_q      <= tick && tick_pending_q && (state_q != StArb);
      if (timeout_set) timeout_q <= 1'b1;
      else if (err_clr) timeout_q <= 1'b0;
      if (latch) begin
        frame_q      <= sel_frame;
        src_q        <= grant_idx;
        last_grant_q <= grant_idx;
      end
      if (frame_done) count_q <= count_q + 16'd1;
    end
  end

  assign ack         = ack_q;
  assign drv_update  = update_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;
  assign drv_frame   = frame_q;
  assign active_src  = src_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Directed bench for ws2812_frame_scheduler: a round-robin vector table plus hand-timed
// sequences for latency, watchdog, overrun and asynchronous reset.
module tb_ws2812_frame_scheduler;

  localparam logic [255:0] FrameA = {16{16'hA5C3}};
  localparam logic [255:0] FrameB = {8{32'h0F1E_2D3C}};

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [511:0] frame_in;
  logic [1:0]   ack;
  logic         drv_busy = 1'b0;
  logic         drv_update;
  logic [255:0] drv_frame;
  logic [0:0]   active_src;
  logic [15:0]  frame_count;
  logic         overrun;
  logic         timeout_err;
  logic         err_clr = 1'b0;

  ws2812_frame_scheduler #(
    .NUM_REQ(2), .PIXELS(256), .FRAME_PERIOD(10), .BUSY_TIMEOUT(20)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .req(req), .frame_in(frame_in),
    .ack(ack), .drv_busy(drv_busy), .drv_update(drv_update), .drv_frame(drv_frame),
    .active_src(active_src), .frame_count(frame_count), .overrun(overrun),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  // Event log sampled mid-cycle.
  int         ack_cnt = 0, upd_cnt = 0, ovr_cnt = 0;
  int         ack_cyc = 0, upd_cyc = 0, ovr_cyc = 0;
  logic [1:0] last_ack = '0;
  logic [0:0] last_src = '0;
  logic [255:0] last_frame = '0;
  logic       upd_seen = 1'b0;

  always @(negedge clock) begin
    upd_seen = drv_update;
    if (|ack) begin
      ack_cnt++;
      ack_cyc    = cyc;
      last_ack   = ack;
      last_src   = active_src;
      last_frame = drv_frame;
    end
    if (drv_update) begin
      upd_cnt++;
      upd_cyc = cyc;
    end
    if (overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
  end

  // Driver model: busy for busy_len cycles starting the cycle after an update; 0 = never.
  int busy_len = 3;
  int busy_left = 0;
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      drv_busy  = 1'b0;
      busy_left = 0;
    end else if (upd_seen && busy_len > 0) begin
      drv_busy  = 1'b1;
      busy_left = busy_len - 1;
    end else if (drv_busy) begin
      if (busy_left > 0) busy_left--;
      else drv_busy = 1'b0;
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic hold_reset();
    reset = 1'b0; enable = 1'b0; req = 2'b00; err_clr = 1'b0;
    repeat (3) @(posedge clock);
  endtask

  task automatic release_reset();
    #1 reset = 1'b1;
  endtask

  task automatic wait_neg(input int k);
    do @(negedge clock); while (cyc < k);
  endtask

  task automatic go(output int c0);
    @(posedge clock);
    #1 enable = 1'b1;
    c0 = cyc;
  endtask

  function automatic logic [255:0] frame_of(input int sel);
    case (sel)
      1: return FrameA;
      2: return FrameB;
      default: return '0;
    endcase
  endfunction

  typedef struct {
    logic [1:0] req;
    logic [1:0] exp_ack;
    int         exp_src;
    int         exp_frame;
    int         exp_count;
  } vec_t;

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int c0, c1, a0, u0, o0;
    vecs[0] = '{2'b00, 2'b00, 0, 0, 0};
    vecs[1] = '{2'b11, 2'b01, 0, 1, 1};
    vecs[2] = '{2'b11, 2'b10, 1, 2, 2};
    vecs[3] = '{2'b11, 2'b01, 0, 1, 3};
    vecs[4] = '{2'b11, 2'b10, 1, 2, 4};
    vecs[5] = '{2'b00, 2'b00, 0, 2, 4};
    vecs[6] = '{2'b10, 2'b10, 1, 2, 5};
    vecs[7] = '{2'b01, 2'b01, 0, 1, 6};
    frame_in = {FrameB, FrameA};

    // Reset state
    hold_reset();
    chk("reset_frame", drv_frame, '0);
    chk("reset_outputs", {ack, drv_update, active_src, frame_count, overrun, timeout_err}, '0);
    release_reset();

    // Single frame latency
    req = 2'b01; busy_len = 6; u0 = upd_cnt;
    go(c0);
    wait_neg(c0 + 20);
    chk("t1_count_before", frame_count, 16'd0);
    wait_neg(c0 + 21);
    chk("t1_count_after", frame_count, 16'd1);
    chk("t1_ack_cycle", ack_cyc, c0 + 12);
    chk("t1_ack", last_ack, 2'b01);
    chk("t1_update_cycle", upd_cyc, c0 + 13);
    chk("t1_frame", drv_frame, FrameA);
    chk("t1_frame_at_ack", last_frame, FrameA);
    chk("t1_updates", upd_cnt - u0, 1);

    // Round-robin / idle table
    hold_reset();
    release_reset();
    busy_len = 3; u0 = upd_cnt;
    go(c0);
    for (int i = 0; i < 8; i++) begin
      req = vecs[i].req;
      a0  = ack_cnt;
      if (vecs[i].exp_ack != 2'b00) begin
        for (int w = 0; w < 35 && ack_cnt == a0; w++) @(negedge clock);
        chk($sformatf("v%0d_ack_seen", i), ack_cnt - a0, 1);
        chk($sformatf("v%0d_ack", i), last_ack, vecs[i].exp_ack);
        chk($sformatf("v%0d_src", i), last_src, vecs[i].exp_src);
        for (int w = 0; w < 30 && frame_count != 16'(vecs[i].exp_count); w++)
          @(negedge clock);
      end else begin
        repeat (35) @(negedge clock);
        chk($sformatf("v%0d_no_ack", i), ack_cnt - a0, 0);
      end
      chk($sformatf("v%0d_count", i), frame_count, vecs[i].exp_count);
      chk($sformatf("v%0d_frame", i), drv_frame, frame_of(vecs[i].exp_frame));
      chk($sformatf("v%0d_updates", i), upd_cnt - u0, vecs[i].exp_count);
    end

    // Watchdog in WAIT_HI, error clear, set-beats-clear
    hold_reset();
    release_reset();
    busy_len = 0; req = 2'b01;
    go(c0);
    wait_neg(c0 + 33);
    chk("t4_err_before", timeout_err, 1'b0);
    wait_neg(c0 + 34);
    chk("t4_err_set", timeout_err, 1'b1);
    chk("t4_count", frame_count, 16'd0);
    wait_neg(c0 + 37);
    chk("t4_retry_update", drv_update, 1'b1);
    wait_neg(c0 + 38);
    chk("t4_retry_cycle", upd_cyc, c0 + 37);
    wait_neg(c0 + 39);
    @(posedge clock);
    #1 err_clr = 1'b1;
    wait_neg(c0 + 40);
    chk("t4_err_held", timeout_err, 1'b1);
    @(posedge clock);
    #1 err_clr = 1'b0;
    wait_neg(c0 + 41);
    chk("t4_err_cleared", timeout_err, 1'b0);
    wait_neg(c0 + 56);
    @(posedge clock);
    #1 err_clr = 1'b1;
    wait_neg(c0 + 57);
    chk("t4_err_clear_cycle", timeout_err, 1'b0);
    @(posedge clock);
    #1 err_clr = 1'b0;
    wait_neg(c0 + 58);
    chk("t4_set_wins", timeout_err, 1'b1);

    // Busy spans two ticks but stays inside the watchdog window
    hold_reset();
    release_reset();
    busy_len = 16; req = 2'b01; o0 = ovr_cnt;
    go(c0);
    wait_neg(c0 + 35);
    chk("t5_overrun_count", ovr_cnt - o0, 1);
    chk("t5_overrun_cycle", ovr_cyc, c0 + 30);
    chk("t5_next_update", upd_cyc, c0 + 34);
    chk("t5_count", frame_count, 16'd1);

    // Asynchronous reset mid-WAIT_LO, then first grant goes to source 0
    hold_reset();
    release_reset();
    busy_len = 10; req = 2'b01;
    go(c0);
    wait_neg(c0 + 17);
    chk("t6_frame_before", drv_frame, FrameA);
    @(posedge clock);
    #3 reset = 1'b0;
    enable = 1'b0;
    #1;
    chk("t6_async_frame", drv_frame, '0);
    chk("t6_async_outputs",
        {ack, drv_update, active_src, frame_count, overrun, timeout_err}, '0);
    req = 2'b11;
    @(posedge clock);
    release_reset();
    go(c1);
    wait_neg(c1 + 13);
    chk("t6_ack_cycle", ack_cyc, c1 + 12);
    chk("t6_first_ack", last_ack, 2'b01);
    chk("t6_first_src", last_src, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
